// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU unit: opcode encoding and
// the supported pipeline depth range.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MAC = 3'd5,
    OP_ACC = 3'd6,
    OP_SEL = 3'd7
  } alu_op_e;

  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: decodes the opcode and produces the result
// together with the accumulator value that an accepted op would leave behind.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc_next
);

  // acc arrives already cleared when acc_clr is set, so ACC here is always
  // "whatever acc should be before this op, plus in1".
  always_comb begin
    result   = '0;
    acc_next = acc;
    case (op)
      OP_ADD: result = in1 + in2;
      OP_SUB: result = in1 - in2;
      OP_AND: result = in1 & in2;
      OP_OR:  result = in1 | in2;
      OP_XOR: result = in1 ^ in2;
      OP_MAC: result = in1 * in2 + in3;
      OP_ACC: begin
        acc_next = acc + in1;
        result   = acc + in1;
      end
      OP_SEL: result = (in3 != '0) ? in1 : in2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_unit.sv
// Pipelined ALU with a STAGES-deep output register chain, valid/ready
// handshake with backpressure and a persistent accumulator.
module alu_pipe_unit
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       alu_func,
  input  logic             acc_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("alu_pipe_unit: STAGES must be within 1..4");
    end
  endgenerate

  logic [WIDTH-1:0] stage_data [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_in;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] acc_next;
  alu_op_e          op_sel;
  logic             advance;
  logic             acc_load;

  assign op_sel    = alu_op_e'(alu_func);
  assign out_valid = stage_valid[STAGES-1];
  assign data_out  = stage_data[STAGES-1];
  assign advance   = en && (!out_valid || out_ready);
  assign in_ready  = advance;
  assign acc_in    = acc_clr ? '0 : acc_q;
  assign acc_load  = advance && (acc_clr || (in_valid && op_sel == OP_ACC));

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .op      (op_sel),
    .in1     (data_in1),
    .in2     (data_in2),
    .in3     (data_in3),
    .acc     (acc_in),
    .result  (alu_result),
    .acc_next(acc_next)
  );

  // Bubbles travel as invalid entries so every stage shifts together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= '0;
      for (int i = 0; i < STAGES; i++) stage_data[i] <= '0;
    end else if (advance) begin
      stage_valid[0] <= in_valid;
      stage_data[0]  <= alu_result;
      for (int i = 1; i < STAGES; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  // acc moves at accept time, so back-to-back ACC ops chain without hazard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (acc_load) begin
      acc_q <= in_valid ? acc_next : '0;
    end
  end

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Self-checking bench for alu_pipe_unit: directed scenarios plus a random
// stream, scored against a queue-based transaction model.
module tb_alu_pipe_unit;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  typedef struct {
    logic [31:0] data;
    int          age;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  alu_func;
  logic        acc_clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in1;
  logic [31:0] data_in2;
  logic [31:0] data_in3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [31:0] acc_m  = '0;
  item_t       q[$];
  logic [31:0] out_log[$];

  always #5 clk = ~clk;

  alu_pipe_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .alu_func (alu_func),
    .acc_clr  (acc_clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics of one accepted instruction, including acc side effects.
  task automatic ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic clr, output logic [31:0] r);
    logic [31:0] prod;
    if (clr) acc_m = '0;
    case (f)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin prod = a * b; r = prod + c; end
      3'd6: begin acc_m = acc_m + a; r = acc_m; end
      default: r = (c != 0) ? a : b;
    endcase
  endtask

  // Drive one cycle, score outputs against the model, then step past the edge.
  task automatic apply_stimulus(input logic v, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] c, input logic clr,
                                input logic e, input logic ordy, output logic accepted);
    logic        exp_ov;
    logic        exp_adv;
    logic [31:0] r;
    item_t       it;
    in_valid = v; alu_func = f; data_in1 = a; data_in2 = b; data_in3 = c;
    acc_clr = clr; en = e; out_ready = ordy;
    #1;
    exp_ov  = (q.size() > 0) && (q[0].age == STAGES - 1);
    exp_adv = e && (!exp_ov || ordy);
    check_output("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    if (exp_ov) check_output("data_out", data_out, q[0].data);
    check_output("in_ready", {31'b0, in_ready}, {31'b0, exp_adv});
    accepted = exp_adv && v;
    if (exp_adv) begin
      if (exp_ov) begin
        out_log.push_back(data_out);
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (v) begin
        ref_model(f, a, b, c, clr, r);
        it.data = r;
        it.age  = 0;
        q.push_back(it);
      end else if (clr) begin
        acc_m = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && q.size() > 0; i++)
      apply_stimulus(1'b0, 3'd0, 0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    check_output("drain_empty", q.size(), 0);
  endtask

  task automatic check_log(input string tag, input logic [31:0] exp []);
    check_output({tag, "_count"}, out_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      check_output(tag, out_log[i], exp[i]);
  endtask

  initial begin
    logic        acc;
    logic [31:0] exp_vals [];
    int          k;
    int          cyc;

    rst = 1'b0; en = 1'b0; alu_func = 3'd0; acc_clr = 1'b0; in_valid = 1'b0;
    data_in1 = '0; data_in2 = '0; data_in3 = '0; out_ready = 1'b1;
    #3;
    check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("reset_data_out", data_out, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD wraps and shows up after STAGES edges.
    apply_stimulus(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b1, 1'b1, acc);
    check_output("latency_not_yet", {31'b0, out_valid}, 32'd0);
    apply_stimulus(1'b0, 3'd0, 0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    check_output("latency_valid", {31'b0, out_valid}, 32'd1);
    check_output("add_wrap", data_out, 32'd0);
    apply_stimulus(1'b1, 3'd1, 32'd3, 32'd5, 0, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b0, 3'd0, 0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    check_output("sub_neg", data_out, 32'hFFFF_FFFE);
    drain();

    // Eight back-to-back ADDs with a three-cycle consumer stall mid-stream.
    out_log.delete();
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      apply_stimulus(1'b1, 3'd0, k * 3, 100 + k, 0, 1'b0, 1'b1, !(cyc >= 3 && cyc <= 5), acc);
      if (acc) k++;
      cyc++;
    end
    check_output("stream_accepted", k, 8);
    drain();
    exp_vals = new[8];
    foreach (exp_vals[i]) exp_vals[i] = i * 4 + 100;
    check_log("stream", exp_vals);

    // Accumulator chain, then clear-and-add.
    out_log.delete();
    apply_stimulus(1'b1, 3'd6, 32'd1, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b1, 3'd6, 32'd2, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b1, 3'd6, 32'd3, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b1, 3'd6, 32'd10, 0, 0, 1'b1, 1'b1, 1'b1, acc);
    drain();
    exp_vals = '{32'd1, 32'd3, 32'd6, 32'd10};
    check_log("acc_chain", exp_vals);

    // MAC keeps the low product bits; SEL with zero in3 picks in2.
    out_log.delete();
    apply_stimulus(1'b1, 3'd5, 32'h0001_0000, 32'h0001_0000, 32'd7, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b1, 3'd7, 32'hAAAA_0000, 32'h0000_BBBB, 32'd0, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b1, 3'd7, 32'hAAAA_0000, 32'h0000_BBBB, 32'd9, 1'b0, 1'b1, 1'b1, acc);
    drain();
    exp_vals = '{32'd7, 32'h0000_BBBB, 32'hAAAA_0000};
    check_log("mac_sel", exp_vals);

    // en low freezes everything and ignores acc_clr.
    out_log.delete();
    apply_stimulus(1'b1, 3'd6, 32'd4, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b0, 3'd0, 0, 0, 0, 1'b0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, 3'd6, 32'd50, 0, 0, 1'b1, 1'b0, 1'b1, acc);
    check_output("en_low_hold", data_out, 32'd14);
    apply_stimulus(1'b1, 3'd6, 32'd1, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    drain();
    exp_vals = '{32'd14, 32'd15};
    check_log("en_low", exp_vals);

    // Asynchronous reset with a full, stalled pipe.
    apply_stimulus(1'b1, 3'd0, 32'd1, 32'd1, 0, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b1, 3'd0, 32'd2, 32'd2, 0, 1'b0, 1'b1, 1'b1, acc);
    apply_stimulus(1'b1, 3'd0, 32'd3, 32'd3, 0, 1'b0, 1'b1, 1'b0, acc);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_output("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("midreset_data_out", data_out, 32'd0);
    q.delete();
    acc_m = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    out_log.delete();
    apply_stimulus(1'b1, 3'd6, 32'd5, 0, 0, 1'b0, 1'b1, 1'b1, acc);
    drain();
    exp_vals = '{32'd5};
    check_log("post_reset_acc", exp_vals);

    // Random traffic with random backpressure, enable and clears.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 3)),
                     $urandom(),
                     ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom(),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 2) != 0, acc);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
